axi_lite_ram: RTL and testbench
===============================

AXI_LITE_RAM -- requirements
Module: axi_lite_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port axi_araddr, input, 32 bits: read address.
REQ-007 Port axi_arvalid, input, 1 bit; port axi_arready, output, 1 bit; port axi_arprot, input, 3 bits (ignored).
REQ-008 Port axi_rdata, output, 32 bits; port axi_rresp, output, 2 bits; port axi_rvalid, output, 1 bit; port axi_rready, input, 1 bit.
REQ-009 Port axi_awaddr, input, 32 bits; port axi_awvalid, input, 1 bit; port axi_awready, output, 1 bit; port axi_awprot, input, 3 bits (ignored).
REQ-010 Port axi_wdata, input, 32 bits; port axi_wstrb, input, 4 bits; port axi_wvalid, input, 1 bit; port axi_wready, output, 1 bit.
REQ-011 Port axi_bresp, output, 2 bits; port axi_bvalid, output, 1 bit; port axi_bready, input, 1 bit.

Function
REQ-012 SHALL act as an AXI4-Lite responder; a handshake completes on a rising edge where valid and ready are both high.
REQ-013 Address decode SHALL use index = (addr - BASE_ADDR) >> 2; addr[1:0] is ignored.
REQ-014 An address SHALL be in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
REQ-015 The read FSM SHALL have two states, R_IDLE and R_DATA.
REQ-016 In R_IDLE, axi_arready SHALL be 1 and axi_rvalid SHALL be 0.
REQ-017 An AR handshake SHALL move the FSM to R_DATA, with rvalid=1 in the next cycle (latency 1).
REQ-018 On an AR handshake, rdata SHALL load mem[index] and rresp SHALL be 2'b00 if in range; otherwise rdata SHALL be 0 and rresp SHALL be 2'b10 (SLVERR).
REQ-019 In R_DATA, arready SHALL be 0, and rvalid, rdata and rresp SHALL hold until rready=1; then the FSM SHALL return to R_IDLE.
REQ-020 There SHALL be at most one outstanding read; there is no read-ahead.
REQ-021 Write address and write data SHALL be captured independently, in either order or in the same cycle.
REQ-022 axi_awready SHALL equal !aw_held && !bvalid, where aw_held flags a captured address awaiting its data.
REQ-023 axi_wready SHALL equal !w_held && !bvalid, where w_held flags captured data awaiting its address.
REQ-024 On the edge where the second of AW/W arrives (or both arrive together), the write SHALL commit, bvalid SHALL go to 1, and both held flags SHALL clear.
REQ-025 A commit SHALL write byte lane i of mem[index] only when wstrb[i]=1; wstrb=0 SHALL be accepted and change nothing.
REQ-026 bresp SHALL be 2'b00 for an in-range write; for an out-of-range write it SHALL be 2'b10, with no write performed.
REQ-027 bvalid and bresp SHALL hold until bready=1 and SHALL clear on that edge; AW and W SHALL not be accepted while bvalid=1.
REQ-028 The read and write paths SHALL run concurrently and independently.
REQ-029 If an AR handshake and a write commit to the same index occur on the same edge, the read SHALL return the pre-write data.
REQ-030 Outputs SHALL be registered; no output SHALL depend combinationally on any valid or ready input, except as stated in REQ-022/023, which use only internal state.
REQ-031 Memory contents SHALL be undefined after power-up and SHALL not be cleared by rst.

Reset
REQ-032 While rst=1 at an edge: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
REQ-033 Reset SHALL clear aw_held and w_held and return the read FSM to R_IDLE.
REQ-034 A reset mid-transaction SHALL abandon the transaction: no response is issued, and a write whose AW and W had not both arrived SHALL not commit.
REQ-035 In the first cycle after rst falls, arready=1, awready=1 and wready=1.

Verification
REQ-036 AW 0x10, W 0xDEADBEEF, wstrb 4'hF in the same cycle -> bvalid next cycle with bresp 00; then AR 0x10 -> rvalid one cycle after the handshake with rdata 0xDEADBEEF and rresp 00.
REQ-037 W 0x000000AA (wstrb 4'h1) issued 3 cycles before AW 0x10 -> wready=0 while held, commit on the AW edge, then read 0x10 returns 0xDEADBEAA.
REQ-038 AR 0x10 with rready held low for 5 cycles -> rvalid and rdata stable for all 5 cycles, arready=0 throughout; after rready=1, arready=1 in the next cycle.
REQ-039 Write and read to BASE_ADDR + 4*DEPTH_WORDS -> bresp 10 and rresp 10 with rdata 0; a subsequent read of index DEPTH_WORDS-1 is unchanged.
REQ-040 AR 0x20 on the same edge as a write commit of 0x12345678 to 0x20 (old value 0) -> rdata 0; the next read of 0x20 returns 0x12345678.
REQ-041 Assert rst after AW 0x30 but before its W -> no bvalid; after reset, a read of 0x30 returns the old contents.

Source files
------------

// File: rtl/axi_lite_ram_if.sv
// AXI4-Lite bus bundle for the on-chip RAM responder.
// The master modport is the requesting side; the slave modport is the RAM.
interface axi_lite_ram_if;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    modport master (
        output axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        output axi_awaddr, axi_awvalid, axi_awprot,
        output axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid
    );

    modport slave (
        input  axi_araddr, axi_arvalid, axi_arprot, axi_rready,
        input  axi_awaddr, axi_awvalid, axi_awprot,
        input  axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid
    );
endinterface

// File: rtl/axi_lite_ram.sv
// AXI4-Lite word-addressed RAM with byte strobes, SLVERR on out-of-range access,
// independent read and write channels and one outstanding transaction per side.
module axi_lite_ram #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    axi_lite_ram_if.slave axi
);
    localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    function automatic logic in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SPAN);
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    r_state_t    r_state, r_next;
    logic        arready_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        aw_held, w_held, bvalid_q, rst_q;
    logic [1:0]  bresp_q;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;

    logic        awready, wready, ar_fire, aw_fire, w_fire, commit, ar_ok, wr_ok;
    logic [31:0] ar_off, wr_addr, wr_off, wr_data;
    logic [3:0]  wr_strb;
    logic [IDX_W-1:0] ar_idx, wr_idx;
    logic        unused_bits;

    // rst_q keeps the write channel closed for the cycle that follows a reset edge
    assign awready = !aw_held && !bvalid_q && !rst_q;
    assign wready  = !w_held && !bvalid_q && !rst_q;

    assign ar_fire = axi.axi_arvalid && arready_q;
    assign aw_fire = axi.axi_awvalid && awready;
    assign w_fire  = axi.axi_wvalid && wready;
    assign commit  = (aw_held || aw_fire) && (w_held || w_fire);

    assign ar_off  = axi.axi_araddr - BASE_ADDR;
    assign ar_idx  = ar_off[IDX_W+1:2];
    assign ar_ok   = in_range(axi.axi_araddr);

    assign wr_addr = aw_fire ? axi.axi_awaddr : aw_addr_q;
    assign wr_data = w_fire ? axi.axi_wdata : w_data_q;
    assign wr_strb = w_fire ? axi.axi_wstrb : w_strb_q;
    assign wr_off  = wr_addr - BASE_ADDR;
    assign wr_idx  = wr_off[IDX_W+1:2];
    assign wr_ok   = in_range(wr_addr);

    assign unused_bits = ^{axi.axi_arprot, axi.axi_awprot, ar_off, wr_off};

    assign axi.axi_arready = arready_q;
    assign axi.axi_rvalid  = (r_state == R_DATA);
    assign axi.axi_rdata   = rdata_q;
    assign axi.axi_rresp   = rresp_q;
    assign axi.axi_awready = awready;
    assign axi.axi_wready  = wready;
    assign axi.axi_bvalid  = bvalid_q;
    assign axi.axi_bresp   = bresp_q;

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (ar_fire) r_next = R_DATA;
            R_DATA: if (axi.axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read data is sampled from mem before this edge's write lands, giving pre-write data on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            if (ar_fire) begin
                rdata_q <= ar_ok ? mem[ar_idx] : 32'h0;
                rresp_q <= ar_ok ? 2'b00 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= 2'b00;
            rst_q    <= 1'b1;
        end else begin
            rst_q <= 1'b0;
            if (commit) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? 2'b00 : 2'b10;
            end else begin
                if (aw_fire) aw_held <= 1'b1;
                if (w_fire) w_held <= 1'b1;
                if (bvalid_q && axi.axi_bready) bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (aw_fire) aw_addr_q <= axi.axi_awaddr;
        if (w_fire) begin
            w_data_q <= axi.axi_wdata;
            w_strb_q <= axi.axi_wstrb;
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (!rst && commit && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_ram.sv
// Directed bench for axi_lite_ram: a transaction-level model is checked against the DUT
// every cycle, and directed vectors pin key values with hand-computed literals.
module tb_axi_lite_ram;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    axi_lite_ram_if bus();

    axi_lite_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk),
        .rst(rst),
        .axi(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: expected bus state derived from the AXI-Lite rules at each rising edge
    logic [31:0] mdl_mem [int];
    bit          mdl_on = 0, m_rst = 0, ready_ok = 0;
    bit          e_rvalid = 0, e_bvalid = 0, aw_pend = 0, w_pend = 0;
    logic [31:0] e_rdata = 0, pend_addr = 0, pend_data = 0;
    logic [1:0]  e_rresp = 0, e_bresp = 0;
    logic [3:0]  pend_strb = 0;

    function automatic bit mdl_in_range(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * DEPTH);
    endfunction

    always @(posedge clk) begin
        bit arr, awr, wr;
        int idx;
        logic [31:0] word;
        mdl_on = 1;
        if (rst) begin
            m_rst = 1; ready_ok = 0; e_rvalid = 0; e_bvalid = 0;
            e_rdata = 0; e_rresp = 0; e_bresp = 0; aw_pend = 0; w_pend = 0;
        end else begin
            m_rst = 0;
            arr = ready_ok && !e_rvalid;
            awr = ready_ok && !aw_pend && !e_bvalid;
            wr  = ready_ok && !w_pend && !e_bvalid;
            if (e_rvalid && bus.axi_rready) e_rvalid = 0;
            else if (arr && bus.axi_arvalid) begin
                e_rvalid = 1;
                if (mdl_in_range(bus.axi_araddr)) begin
                    idx = int'((bus.axi_araddr - BASE) >> 2);
                    e_rdata = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
                    e_rresp = 2'b00;
                end else begin
                    e_rdata = 0;
                    e_rresp = 2'b10;
                end
            end
            if (e_bvalid && bus.axi_bready) e_bvalid = 0;
            if (awr && bus.axi_awvalid) begin aw_pend = 1; pend_addr = bus.axi_awaddr; end
            if (wr && bus.axi_wvalid) begin
                w_pend = 1; pend_data = bus.axi_wdata; pend_strb = bus.axi_wstrb;
            end
            if (aw_pend && w_pend) begin
                aw_pend = 0; w_pend = 0; e_bvalid = 1;
                if (mdl_in_range(pend_addr)) begin
                    idx  = int'((pend_addr - BASE) >> 2);
                    word = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
                    for (int i = 0; i < 4; i++)
                        if (pend_strb[i]) word[8*i +: 8] = pend_data[8*i +: 8];
                    mdl_mem[idx] = word;
                    e_bresp = 2'b00;
                end else e_bresp = 2'b10;
            end
            ready_ok = 1;
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            check_output("cmp_arready", bus.axi_arready, ready_ok && !e_rvalid);
            check_output("cmp_awready", bus.axi_awready, ready_ok && !aw_pend && !e_bvalid);
            check_output("cmp_wready", bus.axi_wready, ready_ok && !w_pend && !e_bvalid);
            check_output("cmp_rvalid", bus.axi_rvalid, e_rvalid);
            check_output("cmp_bvalid", bus.axi_bvalid, e_bvalid);
            if (e_rvalid || m_rst) begin
                check_output("cmp_rdata", bus.axi_rdata, e_rdata);
                check_output("cmp_rresp", bus.axi_rresp, e_rresp);
            end
            if (e_bvalid || m_rst) check_output("cmp_bresp", bus.axi_bresp, e_bresp);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        bit got = 0;
        resp = 2'bxx;
        bus.axi_bready = 1;
        for (int n = 0; n < 50 && !got; n++) begin
            if (bus.axi_bvalid) begin got = 1; resp = bus.axi_bresp; end
            tick();
        end
        bus.axi_bready = 0;
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL b_timeout: got no bvalid expected bvalid within 50 cycles");
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        bit aw_ack, w_ack;
        @(negedge clk);
        bus.axi_awaddr = addr; bus.axi_awvalid = 1;
        bus.axi_wdata = data; bus.axi_wstrb = strb; bus.axi_wvalid = 1;
        for (int n = 0; n < 50 && (bus.axi_awvalid || bus.axi_wvalid); n++) begin
            aw_ack = bus.axi_awvalid && bus.axi_awready;
            w_ack  = bus.axi_wvalid && bus.axi_wready;
            tick();
            if (aw_ack) bus.axi_awvalid = 0;
            if (w_ack) bus.axi_wvalid = 0;
        end
        if (bus.axi_awvalid || bus.axi_wvalid) begin
            checks++; errors++;
            $display("[TB] FAIL aw_w_timeout: got no handshake expected handshake within 50 cycles");
            bus.axi_awvalid = 0; bus.axi_wvalid = 0;
        end
        wait_b(resp);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ack = 0, got = 0;
        data = 'x; resp = 'x;
        @(negedge clk);
        bus.axi_araddr = addr; bus.axi_arvalid = 1;
        for (int n = 0; n < 50 && !ack; n++) begin
            ack = bus.axi_arready;
            tick();
        end
        bus.axi_arvalid = 0;
        bus.axi_rready = 1;
        for (int n = 0; n < 50 && ack && !got; n++) begin
            if (bus.axi_rvalid) begin got = 1; data = bus.axi_rdata; resp = bus.axi_rresp; end
            tick();
        end
        bus.axi_rready = 0;
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL r_timeout: got no read response expected response within 50 cycles");
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    task automatic apply_stimulus(input string name, input vec_t v);
        logic [1:0]  br, rr;
        logic [31:0] rd;
        do_write(v.addr, v.data, v.strb, br);
        check_output({name, "_bresp"}, br, v.bresp);
        do_read(v.addr, rd, rr);
        check_output({name, "_rdata"}, rd, v.rdata);
        check_output({name, "_rresp"}, rr, v.rresp);
    endtask

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rd;
        vec_t vecs[5];

        bus.axi_araddr = 0; bus.axi_arvalid = 0; bus.axi_arprot = 0; bus.axi_rready = 0;
        bus.axi_awaddr = 0; bus.axi_awvalid = 0; bus.axi_awprot = 0;
        bus.axi_wdata = 0; bus.axi_wstrb = 0; bus.axi_wvalid = 0; bus.axi_bready = 0;

        // reset values, then all channels open one cycle after release
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_arready", bus.axi_arready, 0);
        check_output("rst_awready", bus.axi_awready, 0);
        check_output("rst_wready", bus.axi_wready, 0);
        check_output("rst_rdata", bus.axi_rdata, 0);
        rst = 0;
        tick();
        check_output("post_rst_arready", bus.axi_arready, 1);
        check_output("post_rst_awready", bus.axi_awready, 1);
        check_output("post_rst_wready", bus.axi_wready, 1);

        do_write(32'h20, 32'h0, 4'hF, br);
        do_write(32'hFC, 32'h0, 4'hF, br);
        do_write(32'h30, 32'hCAFEF00D, 4'hF, br);

        // AW and W together, bvalid on the following cycle
        @(negedge clk);
        bus.axi_awaddr = 32'h10; bus.axi_awvalid = 1;
        bus.axi_wdata = 32'hDEADBEEF; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1;
        tick();
        bus.axi_awvalid = 0; bus.axi_wvalid = 0;
        check_output("same_cycle_bvalid", bus.axi_bvalid, 1);
        wait_b(br);
        check_output("same_cycle_bresp", br, 2'b00);
        do_read(32'h10, rd, rr);
        check_output("same_cycle_rdata", rd, 32'hDEADBEEF);
        check_output("same_cycle_rresp", rr, 2'b00);

        // W three cycles ahead of AW
        @(negedge clk);
        bus.axi_wdata = 32'h0000_00AA; bus.axi_wstrb = 4'h1; bus.axi_wvalid = 1;
        tick();
        bus.axi_wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            check_output("w_first_wready", bus.axi_wready, 0);
            check_output("w_first_bvalid", bus.axi_bvalid, 0);
            if (i < 2) tick();
        end
        bus.axi_awaddr = 32'h10; bus.axi_awvalid = 1;
        tick();
        bus.axi_awvalid = 0;
        check_output("w_first_commit", bus.axi_bvalid, 1);
        wait_b(br);
        do_read(32'h10, rd, rr);
        check_output("w_first_rdata", rd, 32'hDEADBEAA);

        // read response held while rready is low
        @(negedge clk);
        bus.axi_araddr = 32'h10; bus.axi_arvalid = 1;
        tick();
        bus.axi_arvalid = 0;
        for (int i = 0; i < 5; i++) begin
            check_output("hold_rvalid", bus.axi_rvalid, 1);
            check_output("hold_rdata", bus.axi_rdata, 32'hDEADBEAA);
            check_output("hold_arready", bus.axi_arready, 0);
            tick();
        end
        bus.axi_rready = 1;
        tick();
        bus.axi_rready = 0;
        check_output("hold_release_arready", bus.axi_arready, 1);

        vecs[0] = '{32'h10, 32'h11223344, 4'b0110, 2'b00, 32'hDE2233AA, 2'b00};
        vecs[1] = '{32'h10, 32'hFFFFFFFF, 4'b0000, 2'b00, 32'hDE2233AA, 2'b00};
        vecs[2] = '{32'h10, 32'h55667788, 4'b1000, 2'b00, 32'h552233AA, 2'b00};
        vecs[3] = '{32'h13, 32'h0BADF00D, 4'b1111, 2'b00, 32'h0BADF00D, 2'b00};
        vecs[4] = '{32'h100, 32'hA5A5A5A5, 4'b1111, 2'b10, 32'h0, 2'b10};
        for (int i = 0; i < 5; i++) apply_stimulus($sformatf("vec%0d", i), vecs[i]);
        do_read(32'hFC, rd, rr);
        check_output("last_word_rdata", rd, 32'h0);
        check_output("last_word_rresp", rr, 2'b00);

        // read and write commit to the same word on one edge
        @(negedge clk);
        bus.axi_araddr = 32'h20; bus.axi_arvalid = 1;
        bus.axi_awaddr = 32'h20; bus.axi_awvalid = 1;
        bus.axi_wdata = 32'h12345678; bus.axi_wstrb = 4'hF; bus.axi_wvalid = 1;
        tick();
        bus.axi_arvalid = 0; bus.axi_awvalid = 0; bus.axi_wvalid = 0;
        check_output("collide_rvalid", bus.axi_rvalid, 1);
        check_output("collide_rdata", bus.axi_rdata, 32'h0);
        check_output("collide_bvalid", bus.axi_bvalid, 1);
        bus.axi_rready = 1; bus.axi_bready = 1;
        tick();
        bus.axi_rready = 0; bus.axi_bready = 0;
        do_read(32'h20, rd, rr);
        check_output("collide_after_rdata", rd, 32'h12345678);

        // reset between AW and W abandons the write
        @(negedge clk);
        bus.axi_awaddr = 32'h30; bus.axi_awvalid = 1;
        tick();
        bus.axi_awvalid = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("abandon_bvalid", bus.axi_bvalid, 0);
        end
        do_read(32'h30, rd, rr);
        check_output("abandon_rdata", rd, 32'hCAFEF00D);
        check_output("abandon_rresp", rr, 2'b00);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
